// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - period tick timer with STOPPED/RUNNING/PAUSED control FSM
// Optional shortened soft-drop period is enabled by defining TICK_TIMER_SOFTDROP_EN.
module tick_timer #(
  parameter int                CNT_W          = 32,
  parameter int                TICK_W         = 3,
  parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(10000000),
  parameter int                SOFT_SHIFT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              forceReset,
  input  logic              softDrop,
  input  logic [CNT_W-1:0]  period,
  output logic [TICK_W-1:0] sec,
  output logic              tick,
  output logic              wrap,
  output logic              running
);

  typedef enum logic [1:0] {
    S_STOPPED = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period_q;

  logic             w_count_en;
  logic             w_soft_sel;
  logic [CNT_W-1:0] w_soft_period;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] w_term;
  logic             w_hit;

  // Counting happens on any edge that leaves the timer in RUNNING, including
  // the edge that resumes from PAUSED.
  assign w_count_en    = (r_state != S_STOPPED) && !stop && !pause;
  assign w_soft_period = r_period_q >> SOFT_SHIFT;

`ifdef TICK_TIMER_SOFTDROP_EN
  assign w_soft_sel = softDrop && w_count_en;
`else
  logic w_unused;
  assign w_unused   = softDrop;
  assign w_soft_sel = 1'b0;
`endif

  assign w_base  = w_soft_sel ? w_soft_period : r_period_q;
  assign w_eff   = (w_base == '0) ? CNT_W'(1) : w_base;
  assign w_term  = w_eff - CNT_W'(1);
  // >= rather than == so a shortened period taking effect late still fires at once.
  assign w_hit   = r_count >= w_term;
  assign running = (r_state == S_RUNNING);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_STOPPED;
      r_count    <= '0;
      r_period_q <= DEFAULT_PERIOD;
      sec        <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (forceReset) begin
        r_count    <= '0;
        sec        <= '0;
        r_period_q <= period;
      end else begin
        case (r_state)
          S_STOPPED: begin
            if (start && !stop) begin
              r_state    <= S_RUNNING;
              r_period_q <= period;
              r_count    <= '0;
            end
          end
          default: begin
            if (stop) begin
              r_state <= S_STOPPED;
              r_count <= '0;
            end else if (pause) begin
              r_state <= S_PAUSED;
            end else begin
              r_state <= S_RUNNING;
              if (w_hit) begin
                r_count    <= '0;
                tick       <= 1'b1;
                sec        <= sec + TICK_W'(1);
                wrap       <= &sec;
                r_period_q <= period;
              end else begin
                r_count <= r_count + CNT_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - directed self-checking bench for tick_timer
module tb_tick_timer;

  localparam int CNT_W  = 32;
  localparam int TICK_W = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              pause;
  logic              forceReset;
  logic              softDrop;
  logic [CNT_W-1:0]  period;
  logic [TICK_W-1:0] sec;
  logic              tick;
  logic              wrap;
  logic              running;

  int n_checks;
  int n_fail;

  tick_timer #(
    .CNT_W (CNT_W),
    .TICK_W(TICK_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .forceReset(forceReset),
    .softDrop  (softDrop),
    .period    (period),
    .sec       (sec),
    .tick      (tick),
    .wrap      (wrap),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    forceReset = 1'b0;
    softDrop   = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0;
    forceReset = 1'b0; softDrop = 1'b0; period = 32'd3;
    step();
    n_checks++;
    if (sec !== 3'd0) begin n_fail++; $display("FAIL reset_sec got %0d exp 0", sec); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0b exp 0", tick); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %0b exp 0", wrap); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b exp 0", running); end
    step();
    step();
    n_checks++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_override running=%0b tick=%0b exp 0 0", running, tick);
    end
    rst = 1'b0; start = 1'b0;
    step();
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle got %0b exp 0", running); end
  endtask

  task automatic test_startup();
    do_reset();
    period = 32'd5;
    start  = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (running !== 1'b1 || tick !== 1'b0) begin
      n_fail++; $display("FAIL startup_enter running=%0b tick=%0b exp 1 0", running, tick);
    end
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (tick !== (k % 5 == 0) || sec !== 3'(k / 5)) begin
        n_fail++;
        $display("FAIL startup_k%0d tick=%0b sec=%0d exp %0b %0d", k, tick, sec, (k % 5 == 0), k / 5);
      end
    end
  endtask

  task automatic test_wrap();
    int n_tick;
    int n_wrap;
    n_tick = 0; n_wrap = 0;
    do_reset();
    period = 32'd2;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_tick += int'(tick);
      n_wrap += int'(wrap);
      n_checks++;
      if (wrap !== (k == 16) || sec !== 3'((k / 2) % 8)) begin
        n_fail++;
        $display("FAIL wrap_k%0d wrap=%0b sec=%0d exp %0b %0d", k, wrap, sec, (k == 16), (k / 2) % 8);
      end
    end
    n_checks++;
    if (n_tick != 8) begin n_fail++; $display("FAIL wrap_tick_count got %0d exp 8", n_tick); end
    n_checks++;
    if (n_wrap != 1) begin n_fail++; $display("FAIL wrap_pulse_count got %0d exp 1", n_wrap); end
  endtask

  task automatic test_pause();
    do_reset();
    period = 32'd10;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (running !== 1'b0 || tick !== 1'b0 || sec !== 3'd0) begin
        n_fail++;
        $display("FAIL pause_hold_%0d running=%0b tick=%0b sec=%0d exp 0 0 0", k, running, tick, sec);
      end
    end
    pause = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick !== (k == 6) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_resume_k%0d tick=%0b running=%0b exp %0b 1", k, tick, running, (k == 6));
      end
    end
    n_checks++;
    if (sec !== 3'd1) begin n_fail++; $display("FAIL pause_sec got %0d exp 1", sec); end
  endtask

  task automatic test_force_reset();
    do_reset();
    period = 32'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (tick !== 1'b1 || sec !== 3'd1) begin
      n_fail++; $display("FAIL force_pre tick=%0b sec=%0d exp 1 1", tick, sec);
    end
    for (int k = 0; k < 3; k++) step();
    forceReset = 1'b1;
    period     = 32'd6;
    step();
    forceReset = 1'b0;
    n_checks++;
    if (tick !== 1'b0 || wrap !== 1'b0 || sec !== 3'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL force_boundary tick=%0b wrap=%0b sec=%0d running=%0b exp 0 0 0 1", tick, wrap, sec, running);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick !== (k == 6)) begin
        n_fail++; $display("FAIL force_reload_k%0d tick=%0b exp %0b", k, tick, (k == 6));
      end
    end
  endtask

  task automatic test_stop_start();
    do_reset();
    period = 32'd4;
    start  = 1'b1;
    stop   = 1'b1;
    step();
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL stop_wins got %0b exp 0", running); end
    stop = 1'b0;
    step();
    start = 1'b0;
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_accept got %0b exp 1", running); end
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (tick !== 1'b1 || sec !== 3'd1) begin
      n_fail++; $display("FAIL start_ignored tick=%0b sec=%0d exp 1 1", tick, sec);
    end
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (running !== 1'b0 || sec !== 3'd1) begin
      n_fail++; $display("FAIL stop_hold running=%0b sec=%0d exp 0 1", running, sec);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL stopped_quiet_%0d tick=%0b exp 0", k, tick); end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (tick !== (k == 4)) begin
        n_fail++; $display("FAIL restart_k%0d tick=%0b exp %0b", k, tick, (k == 4));
      end
    end
    n_checks++;
    if (sec !== 3'd2) begin n_fail++; $display("FAIL restart_sec got %0d exp 2", sec); end
  endtask

  task automatic test_reload();
    logic exp_tick;
    do_reset();
    period = 32'd8;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 3)  period = 32'd3;
      if (k == 11) period = 32'd0;
      exp_tick = (k == 8) || (k == 11) || (k >= 14);
      n_checks++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL reload_k%0d tick=%0b exp %0b", k, tick, exp_tick);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    period = 32'd5;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (tick !== 1'b0 || running !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_%0d tick=%0b running=%0b exp 0 0", k, tick, running);
      end
    end
  endtask

  task automatic test_softdrop();
    logic exp_tick;
    do_reset();
    period = 32'd64;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    softDrop = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
`ifdef TICK_TIMER_SOFTDROP_EN
      exp_tick = ((k - 1) % 8 == 0);
`else
      exp_tick = (k == 44);
`endif
      n_checks++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL softdrop_k%0d tick=%0b exp %0b", k, tick, exp_tick);
      end
    end
    softDrop = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    forceReset = 1'b0;
    softDrop   = 1'b0;
    period     = '0;
    test_reset();
    test_startup();
    test_wrap();
    test_pause();
    test_force_reset();
    test_stop_start();
    test_reload();
    test_rst_mid();
    test_softdrop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
